// File: rtl/fpu_issue_ctrl.sv
// FPU issue/completion sequencer: accepts one op, waits its table latency, registers the unit result.
// Latency: op with table latency L accepted at edge T presents out_valid in the cycle after edge T+L.
// Backpressure: result held while out_valid && !out_ready; a new op may be accepted on the handshake edge.
module fpu_issue_ctrl #(
  parameter int XLEN   = 32,
  parameter int NUM_OP = 15,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 4,
  parameter logic [NUM_OP*CNT_W-1:0] LAT_TABLE = 60'h1111111111_22111
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_OP-1:0]      op_sel,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic [NUM_OP*XLEN-1:0] unit_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_result,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_err,
  output logic                   busy
);

  localparam int IDX_W = (NUM_OP > 1) ? $clog2(NUM_OP) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] op_idx_q, op_idx_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             legal_q, legal_d;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_err_q, out_err_d;

  logic             accept;
  logic             legal_in;
  logic [IDX_W-1:0] idx_in;
  logic [CNT_W-1:0] lat_raw;
  logic [CNT_W-1:0] lat_eff;
  logic [XLEN-1:0]  sel_result;

  assign in_ready   = !flush && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q != S_IDLE);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign out_err    = out_err_q;

  // Decode incoming one-hot select into an index plus a legality flag
  always_comb begin
    idx_in = '0;
    for (int i = 0; i < NUM_OP; i++) begin
      if (op_sel[i]) idx_in = IDX_W'(i);
    end
    legal_in = $onehot(op_sel);
  end

  // Look up latency and result slice of the latched op; zero latency and illegal ops both run for one cycle
  always_comb begin
    lat_raw    = '0;
    sel_result = '0;
    for (int i = 0; i < NUM_OP; i++) begin
      if (op_idx_q == IDX_W'(i)) begin
        lat_raw    = LAT_TABLE[i*CNT_W +: CNT_W];
        sel_result = unit_result[i*XLEN +: XLEN];
      end
    end
    lat_eff = (!legal_q || (lat_raw == '0)) ? CNT_W'(1) : lat_raw;
  end

  // Next-state logic; flush overrides everything but leaves the last result registers intact
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_idx_d     = op_idx_q;
    tag_d        = tag_q;
    legal_d      = legal_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    out_err_d    = out_err_q;
    if (flush) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_idx_d = idx_in;
            tag_d    = in_tag;
            legal_d  = legal_in;
            cnt_d    = CNT_W'(1);
            state_d  = S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt_q < lat_eff) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            out_result_d = legal_q ? sel_result : '0;
            out_tag_d    = tag_q;
            out_err_d    = !legal_q;
            out_valid_d  = 1'b1;
            state_d      = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            if (accept) begin
              op_idx_d = idx_in;
              tag_d    = in_tag;
              legal_d  = legal_in;
              cnt_d    = CNT_W'(1);
              state_d  = S_EXEC;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_idx_q     <= '0;
      tag_q        <= '0;
      legal_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_idx_q     <= op_idx_d;
      tag_q        <= tag_d;
      legal_q      <= legal_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      out_err_q    <= out_err_d;
    end
  end

endmodule
